// File: rtl/voting_pkg.sv
// Shared definitions for the ballot collector and its tally-side users.
//   N_VOTERS_DEF / BALLOT_W_DEF : default round geometry (4 voters, 2-bit ballots)
//   state_t                     : collector FSM states
//   slot_off()                  : bit offset of a voter's slot in the packed round
package voting_pkg;

   localparam int N_VOTERS_DEF = 4;
   localparam int BALLOT_W_DEF = 2;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // Voter idx occupies [slot_off(idx,w) +: w], voter 0 in the LSBs.
   function automatic int slot_off(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/ballot_slot_bank.sv
// Per-voter ballot storage for one round.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en       : store wr_data into slot wr_id and mark it voted
//   wr_id       : target slot
//   wr_data     : ballot value, stored verbatim
//   clr         : empty every slot (round handed off or aborted)
//   ballots     : packed slots, voter i at slot_off(i, BALLOT_W)
//   voted_mask  : bit i set once slot i holds a ballot
module ballot_slot_bank
   import voting_pkg::*;
#(
   parameter int N_VOTERS = N_VOTERS_DEF,
   parameter int BALLOT_W = BALLOT_W_DEF,
   parameter int ID_W     = $clog2(N_VOTERS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [ID_W-1:0]              wr_id,
   input  logic [BALLOT_W-1:0]          wr_data,
   input  logic                         clr,
   output logic [N_VOTERS*BALLOT_W-1:0] ballots,
   output logic [N_VOTERS-1:0]          voted_mask
);

   for (genvar i = 0; i < N_VOTERS; i++) begin : g_slot
      logic [BALLOT_W-1:0] slot;
      logic                voted;

      always_ff @(posedge clk) begin
         if (!rst_n || clr) begin
            slot  <= '0;
            voted <= 1'b0;
         end else if (wr_en && wr_id == ID_W'(i)) begin
            slot  <= wr_data;
            voted <= 1'b1;
         end
      end

      assign ballots[slot_off(i, BALLOT_W) +: BALLOT_W] = slot;
      assign voted_mask[i] = voted;
   end

endmodule

// File: rtl/ballot_collector.sv
// Collects one ballot per voter (any order) into a packed round and presents
// it to the tally side over a valid/ready handshake.
//   clk, rst_n         : clock, synchronous active-low reset
//   ballot_valid/ready : ballot handshake; ready only while collecting
//   ballot_id/data     : voter index and candidate index
//   round_valid/ready  : round handshake; valid only while presenting
//   round_ballots      : packed round, voter i at [i*BALLOT_W +: BALLOT_W]
//   abort              : discard the current round (beats any same-cycle event)
//   voted_mask         : voters whose ballot is held
//   dup_err, id_err    : one-cycle pulses for dropped duplicate / bad-id ballots
//   round_cnt          : rounds handed off, wrapping
module ballot_collector
   import voting_pkg::*;
#(
   parameter  int N_VOTERS = N_VOTERS_DEF,
   parameter  int BALLOT_W = BALLOT_W_DEF,
   parameter  int CNT_W    = 8,
   localparam int ID_W     = $clog2(N_VOTERS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ballot_valid,
   output logic                         ballot_ready,
   input  logic [ID_W-1:0]              ballot_id,
   input  logic [BALLOT_W-1:0]          ballot_data,
   output logic                         round_valid,
   input  logic                         round_ready,
   output logic [N_VOTERS*BALLOT_W-1:0] round_ballots,
   input  logic                         abort,
   output logic [N_VOTERS-1:0]          voted_mask,
   output logic                         dup_err,
   output logic                         id_err,
   output logic [CNT_W-1:0]             round_cnt
);

   localparam int ID_SPAN = 2 ** ID_W;

   state_t              state, state_nxt;
   logic                in_range;
   logic [N_VOTERS-1:0] id_bit;
   logic                already;
   logic                take;
   logic                wr_en;
   logic                handoff;
   logic                round_full;
   logic                dup_nxt, id_nxt;

   // Only a non-power-of-two voter count can see ids past the last slot.
   if (ID_SPAN == N_VOTERS) begin : g_full_span
      assign in_range = 1'b1;
   end else begin : g_part_span
      assign in_range = ballot_id < ID_W'(N_VOTERS);
   end

   // Shifting past the top bit yields zero, so a bad id never aliases a slot.
   assign id_bit     = N_VOTERS'(1) << ballot_id;
   assign already    = |(voted_mask & id_bit);
   assign round_full = &(voted_mask | id_bit);

   // abort wins over everything in its cycle, including error reporting.
   assign take    = (state == COLLECT) && ballot_valid && !abort;
   assign wr_en   = take && in_range && !already;
   assign dup_nxt = take && in_range && already;
   assign id_nxt  = take && !in_range;
   assign handoff = (state == PRESENT) && round_ready && !abort;

   ballot_slot_bank #(
      .N_VOTERS (N_VOTERS),
      .BALLOT_W (BALLOT_W),
      .ID_W     (ID_W)
   ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_id      (ballot_id),
      .wr_data    (ballot_data),
      .clr        (abort || handoff),
      .ballots    (round_ballots),
      .voted_mask (voted_mask)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (wr_en && round_full) state_nxt = PRESENT;
         PRESENT: if (handoff)             state_nxt = COLLECT;
         default:                          state_nxt = COLLECT;
      endcase
      if (abort) state_nxt = COLLECT;
   end

   // Handshake outputs come straight from the state register.
   assign ballot_ready = (state == COLLECT);
   assign round_valid  = (state == PRESENT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= COLLECT;
         dup_err   <= 1'b0;
         id_err    <= 1'b0;
         round_cnt <= '0;
      end else begin
         state   <= state_nxt;
         dup_err <= dup_nxt;
         id_err  <= id_nxt;
         if (handoff) round_cnt <= round_cnt + 1'b1;
      end
   end

endmodule
